// File: rtl/clk_tick_pkg.sv
// Shared constants and elaboration-time helpers for the clock timebase.
package clk_tick_pkg;

  localparam int CLK_HZ_DEF = 50_000_000;

  // Bits needed to hold values 0..v-1 (never less than 1).
  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int div_sec(input int clk_hz, input int sec_hz);
    return clk_hz / sec_hz;
  endfunction

  function automatic int div_scan(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic int div_fast(input int dsec, input int mult);
    return dsec / mult;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Generic modulo-N counter with enable, sync clear and a registered terminal pulse.
module tick_div
  import clk_tick_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int W = clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// Timebase: seconds tick with half tick and blink, fast-set, pause, clear and trim,
// plus an independent free-running display-scan tick.
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int SEC_HZ    = 1,
  parameter int SCAN_HZ   = 1000,
  parameter int FAST_MULT = 60,
  parameter int TRIM_W    = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     fast,
  input  logic                     clear,
  input  logic signed [TRIM_W-1:0] trim,
  output logic                     tick_sec,
  output logic                     tick_half,
  output logic                     blink,
  output logic                     tick_scan
);

  localparam int DIV_SEC  = div_sec(CLK_HZ, SEC_HZ);
  localparam int DIV_SCAN = div_scan(CLK_HZ, SCAN_HZ);
  localparam int DIV_FAST = div_fast(DIV_SEC, FAST_MULT);
  localparam int CNT_W    = clog2(longint'(DIV_SEC) + (longint'(1) << (TRIM_W - 1)));

  if ((CLK_HZ % SEC_HZ != 0) || (CLK_HZ % SCAN_HZ != 0)) begin : g_chk_div
    $fatal(1, "clk_tick_gen: CLK_HZ must be a multiple of SEC_HZ and SCAN_HZ");
  end
  if (DIV_FAST < 2) begin : g_chk_fast
    $fatal(1, "clk_tick_gen: DIV_FAST must be at least 2");
  end
  if (longint'(DIV_SEC) <= (longint'(1) << (TRIM_W - 1)) + 2) begin : g_chk_trim
    $fatal(1, "clk_tick_gen: trim range too large for DIV_SEC");
  end

  logic [CNT_W-1:0]         cnt, cnt_d;
  logic signed [TRIM_W-1:0] trim_q, trim_d;
  logic [31:0]              period, half, cnt_x;
  logic                     term, mid;
  logic                     sec_d, half_d, blink_d;

  // Period math is done at 32 bits so a negative trim cannot wrap the compare.
  always_comb begin
    period  = fast ? 32'(DIV_FAST) : 32'(DIV_SEC) + 32'(trim_q);
    half    = period >> 1;
    cnt_x   = 32'(cnt);
    term    = en && (cnt_x >= period - 32'd1);
    mid     = en && (cnt_x == half - 32'd1);
    cnt_d   = cnt;
    trim_d  = trim_q;
    blink_d = blink;
    sec_d   = 1'b0;
    half_d  = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      blink_d = 1'b0;
      trim_d  = trim;
    end else if (term) begin
      cnt_d   = '0;
      sec_d   = 1'b1;
      half_d  = 1'b1;
      blink_d = 1'b0;
      trim_d  = trim;
    end else if (en) begin
      cnt_d = cnt + 1'b1;
      if (mid) begin
        half_d  = 1'b1;
        blink_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      trim_q    <= '0;
      tick_sec  <= 1'b0;
      tick_half <= 1'b0;
      blink     <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      trim_q    <= trim_d;
      tick_sec  <= sec_d;
      tick_half <= half_d;
      blink     <= blink_d;
    end
  end

  tick_div #(.N(DIV_SCAN)) u_scan (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (1'b1),
    .clear  (1'b0),
    .tick   (tick_scan)
  );

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised timebase for the digital clock. It divides the board clock into three outputs: a one-cycle seconds tick, a half-period tick with a matching 50 % blink square wave, and an independent display-scan tick. It adds run/pause, a fast-set mode, synchronous clear and signed period trim for calibration. It sits between the board oscillator and the time-keeping counters and display multiplexer, and drives them with clock enables rather than derived clocks.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- SEC_HZ, 1, seconds-tick rate; DIV_SEC = CLK_HZ/SEC_HZ
- SCAN_HZ, 1000, display-scan tick rate; DIV_SCAN = CLK_HZ/SCAN_HZ
- FAST_MULT, 60, speed-up factor in fast mode; DIV_FAST = DIV_SEC/FAST_MULT
- TRIM_W, 8, width of signed trim input
- clk_in  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run (1) / pause (0) for the seconds path
- fast  in  1  fast-set mode select
- clear  in  1  synchronous restart of the seconds period
- trim  in  TRIM_W  signed period correction in clk_in cycles (normal mode only)
- tick_sec  out  1  one-cycle pulse per seconds period
- tick_half  out  1  one-cycle pulse at mid-period and at period end
- blink  out  1  square wave: 0 first half, 1 second half of period
- tick_scan  out  1  one-cycle pulse every DIV_SCAN cycles

## Operation
- Active period P: DIV_FAST if fast=1, else DIV_SEC + trim_q. H = P>>1.
- Counter cnt is CNT_W = clog2(DIV_SEC + 2^(TRIM_W-1)) bits. Reset value 0.
- Terminal condition: en=1 and cnt >= P-1. The >= compare gives an immediate wrap when P shrinks below cnt.
- On terminal: cnt<=0, tick_sec<=1, tick_half<=1, blink<=0, trim_q<=trim.
- On en=1 and cnt==H-1 (not terminal): cnt increments, tick_half<=1, blink<=1.
- Otherwise, with en=1: cnt increments and the tick outputs are 0.
- en=0: cnt, blink and trim_q hold; tick_sec and tick_half are 0.
- clear=1: cnt<=0, blink<=0, trim_q<=trim, all seconds-path ticks 0. clear dominates en and the terminal condition.
- trim is sampled only at wrap, clear or reset (reset value 0). Changes mid-period take effect at the next period. trim_q is ignored when fast=1.
- Scan path: a separate modulo-DIV_SCAN counter that runs whenever rst_n=1. It is unaffected by en, fast and clear.
- Elaboration checks (fatal on failure):
  - CLK_HZ % SEC_HZ == 0 and CLK_HZ % SCAN_HZ == 0
  - DIV_FAST >= 2
  - DIV_SEC > 2^(TRIM_W-1) + 2

## Timing
- All outputs are registered. Reset value of every output is 0, applied asynchronously on rst_n low.
- From reset release with en=1: tick_sec is high for the single cycle after rising edge P, and again every P cycles.
- tick_half fires after edges H and P. blink is high for P-H cycles per period.
- tick_scan is high after edge DIV_SCAN, then every DIV_SCAN cycles.
- Pause: each cycle with en=0 extends the current period by exactly one cycle.
- fast toggled mid-period: the new P applies from the next edge. If cnt >= new P-1, tick_sec fires on that edge.

## Structure
- Package clk_tick_pkg holds:
  - default CLK_HZ constant
  - clog2 helper function
  - divisor-derivation functions (DIV_SEC, DIV_SCAN, DIV_FAST)
- Sub-module tick_div: generic modulo-N counter with enable, sync clear and registered terminal pulse. It is instantiated for the scan path. The seconds path is custom logic in clk_tick_gen.

## Test plan
Parameters: CLK_HZ=100, SEC_HZ=1, SCAN_HZ=25, FAST_MULT=10, TRIM_W=4.
- Reset, then en=1, trim=0, fast=0 -> tick_sec after edges 100, 200, 300; tick_half after 50, 100, 150; blink high during cycles 51–100; tick_scan every 4 cycles starting after edge 4.
- trim=+3 held from cycle 0, changed to -5 at cycle 150 -> periods of 100, 103, then 95 (the -5 is sampled at the wrap following cycle 150).
- fast=1 asserted when cnt=30 -> tick_sec on the next edge, then every 10 cycles; trim=+3 has no effect.
- en=0 for 20 cycles mid-period -> that period lasts 120 cycles; tick_scan cadence unchanged at 4 cycles.
- clear=1 in the cycle where cnt==99 -> no tick_sec, blink=0, next tick_sec 100 cycles later. clear=1 with en=0 -> cnt still resets to 0.
- rst_n low mid-period, between clock edges -> all outputs 0 immediately; after release, first tick_sec after edge 100.
